// File: rtl/rx_uart_gen_pkg.sv
// rx_uart_gen shared types: one-hot receiver states
// and the three-sample majority vote.
package rx_uart_gen_pkg;

  localparam int unsigned ST_IDLE   = 0;
  localparam int unsigned ST_START  = 1;
  localparam int unsigned ST_DATA   = 2;
  localparam int unsigned ST_PARITY = 3;
  localparam int unsigned ST_STOP   = 4;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  function automatic logic majority3(
    input logic [2:0] v
  );
    return (v[0] & v[1]) |
           (v[0] & v[2]) |
           (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/rx_uart_sampler.sv
// rx line conditioning: two-flop synchroniser and a
// tick-gated 3-sample history voted by majority.
module rx_uart_sampler (
  input  logic clock,
  input  logic reset,
  input  logic rx_i,
  input  logic s_tick_i,
  output logic rx_sync_o,
  output logic maj_o
);
  import rx_uart_gen_pkg::*;

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic [2:0] hist_q;
  logic [2:0] hist_d;

  assign sync_d = {sync_q[0], rx_i};

  // Synchroniser resets to the idle-high line level
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // History advances only on oversampling ticks
  always_comb begin
    hist_d = hist_q;
    if (s_tick_i) begin
      hist_d = {hist_q[1:0], sync_q[1]};
    end
  end

  // History register, idle-high after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rx_sync_o = sync_q[1];
  assign maj_o     = majority3(hist_q);

endmodule

// File: rtl/rx_uart_gen.sv
// Parametrised UART receiver with valid/ready output.
// RX_UART_GEN_PARITY_EN adds a parity bit and check.
module rx_uart_gen #(
  parameter int N_DATA     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int N_STOP     = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic              s_tick,
  output logic [N_DATA-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              rx_busy
);
  import rx_uart_gen_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(N_DATA + 1);

  localparam logic [TW-1:0] T_HALF =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DLAST =
    BW'(N_DATA - 1);
  localparam logic [BW-1:0] B_SLAST =
    BW'(N_STOP - 1);

  if (N_DATA < 5 || N_DATA > 9 ||
      OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      (OVERSAMPLE % 2) != 0 ||
      (N_STOP != 1 && N_STOP != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1))
  begin : g_bad_cfg
    $error("rx_uart_gen: bad parameters");
  end

  logic rx_sync;
  logic maj;

  rx_uart_sampler u_sampler (
    .clock     (clock),
    .reset     (reset),
    .rx_i      (rx),
    .s_tick_i  (s_tick),
    .rx_sync_o (rx_sync),
    .maj_o     (maj)
  );

  state_t            state_q;
  state_t            state_d;
  logic [TW-1:0]     tick_q;
  logic [TW-1:0]     tick_d;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     bit_d;
  logic [N_DATA-1:0] shreg_q;
  logic [N_DATA-1:0] shreg_d;
  logic              ferr_q;
  logic              ferr_d;
  logic              done;

  logic [N_DATA-1:0] dout_q;
  logic [N_DATA-1:0] dout_d;
  logic              valid_q;
  logic              valid_d;
  logic              fe_q;
  logic              fe_d;
  logic              ov_q;
  logic              ov_d;

`ifdef RX_UART_GEN_PARITY_EN
  logic perr_q;
  logic perr_d;
  logic pe_q;
  logic pe_d;
  logic par_exp;

  assign par_exp = (^shreg_q) ^ (PARITY_ODD != 0);
`endif

  // Next state, counters, shifter and frame completion
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
`ifdef RX_UART_GEN_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    dout_d  = dout_q;
    valid_d = valid_q & ~dout_ready;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    unique case (1'b1)
      state_q[ST_IDLE]: begin
        if (!rx_sync) begin
          tick_d  = '0;
          state_d = S_START;
        end
      end
      state_q[ST_START]: begin
        if (s_tick) begin
          if (tick_q == T_HALF) begin
            if (!maj) begin
              tick_d  = '0;
              bit_d   = '0;
              ferr_d  = 1'b0;
`ifdef RX_UART_GEN_PARITY_EN
              perr_d  = 1'b0;
`endif
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      state_q[ST_DATA]: begin
        if (s_tick) begin
          if (tick_q == T_LAST) begin
            tick_d  = '0;
            shreg_d = {maj, shreg_q[N_DATA-1:1]};
            if (bit_q == B_DLAST) begin
              bit_d   = '0;
`ifdef RX_UART_GEN_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef RX_UART_GEN_PARITY_EN
      state_q[ST_PARITY]: begin
        if (s_tick) begin
          if (tick_q == T_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            perr_d  = (maj != par_exp);
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      state_q[ST_STOP]: begin
        if (s_tick) begin
          if (tick_q == T_LAST) begin
            tick_d = '0;
            ferr_d = ferr_q | ~maj;
            if (bit_q == B_SLAST) begin
              bit_d   = '0;
              done    = 1'b1;
              state_d = S_IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    if (done) begin
      if (ferr_d) begin
        fe_d = 1'b1;
      end else if (!valid_q || dout_ready) begin
        dout_d  = shreg_q;
        valid_d = 1'b1;
`ifdef RX_UART_GEN_PARITY_EN
        pe_d    = perr_q;
`endif
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
    end
  end

  // Holding register and one-cycle error pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

`ifdef RX_UART_GEN_PARITY_EN
  // Parity flag and its reporting pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      perr_q <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      perr_q <= perr_d;
      pe_q   <= pe_d;
    end
  end

  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign frame_err   = fe_q;
  assign overrun_err = ov_q;
  assign rx_busy     = ~state_q[ST_IDLE];

endmodule

// File: tb/tb_rx_uart_gen.sv
// Directed plus randomised bench for rx_uart_gen
// against a frame-level reference model.
module tb_rx_uart_gen;

  localparam int OS   = 16;
  localparam int ND   = 8;
  localparam int NS   = 1;
  localparam int PODD = 1;
`ifdef RX_UART_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = 1 + ND + PAR + NS;
  localparam int T1 = OS / 2 + OS * (FB - 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          s_tick = 1'b0;
  logic          dout_ready = 1'b1;
  logic [ND-1:0] dout;
  logic          dout_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;
  logic          rx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rx_uart_gen #(
    .N_DATA     (ND),
    .OVERSAMPLE (OS),
    .N_STOP     (NS),
    .PARITY_ODD (PODD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .s_tick      (s_tick),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  logic [ND-1:0] got_q[$];
  logic [ND-1:0] exp_q[$];
  int fe_n = 0, pe_n = 0, ov_n = 0, viol = 0;
  int e_fe = 0, e_pe = 0, e_ov = 0;
  bit mdl_full = 0;

  logic          pv_fe = 0, pv_pe = 0, pv_ov = 0;
  logic          pv_val = 0, pv_xfer = 0;
  logic [ND-1:0] pv_dout = '0;

  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      if (dout_valid && dout_ready)
        got_q.push_back(dout);
      if (frame_err) fe_n++;
      if (parity_err) pe_n++;
      if (overrun_err) ov_n++;
      if ((frame_err && pv_fe) ||
          (parity_err && pv_pe) ||
          (overrun_err && pv_ov))
        viol++;
      if (frame_err && (parity_err || overrun_err))
        viol++;
      if (overrun_err && parity_err) viol++;
      if (pv_val && !pv_xfer && dout !== pv_dout)
        viol++;
    end
    pv_fe   = frame_err;
    pv_pe   = parity_err;
    pv_ov   = overrun_err;
    pv_val  = dout_valid;
    pv_xfer = dout_valid && dout_ready;
    pv_dout = dout;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    repeat ($urandom_range(3, 4)) @(negedge clock);
    s_tick = 1'b1;
    @(negedge clock);
    s_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic release_hold();
    dout_ready = 1'b1;
    repeat (2) @(negedge clock);
    mdl_full = 0;
  endtask

  task automatic sync(input string tag);
    chk({tag, "_nwords"}, 32'(got_q.size()),
        32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk({tag, "_word"}, 32'(got_q[i]),
            32'(exp_q[i]));
    chk({tag, "_fe_cnt"}, 32'(fe_n), 32'(e_fe));
    chk({tag, "_pe_cnt"}, 32'(pe_n), 32'(e_pe));
    chk({tag, "_ov_cnt"}, 32'(ov_n), 32'(e_ov));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(
    input logic [ND-1:0] d,
    input bit            bad_stop,
    input bit            par_flip,
    input int            spike
  );
    bit fe, ov, ld, pe, ev;
    rx = 1'b0;
    ticks(OS / 2);
    chk("busy_in_frame", 32'(rx_busy), 32'd1);
    ticks(OS / 2);
    for (int i = 0; i < ND; i++) begin
      rx = d[i];
      if (i == spike) begin
        ticks(5);
        rx = ~d[i];
        tick();
        rx = d[i];
        ticks(OS - 6);
      end else begin
        ticks(OS);
      end
    end
    if (PAR != 0) begin
      rx = (^d) ^ PODD[0] ^ par_flip;
      ticks(OS);
    end
    for (int s = 0; s < NS; s++) begin
      rx = ~bad_stop;
      if (s == NS - 1) ticks(OS / 2);
      else ticks(OS);
    end
    fe = bad_stop;
    ov = !fe && !dout_ready && mdl_full;
    ld = !fe && !ov;
    pe = ld && par_flip && (PAR != 0);
    ev = ld || (mdl_full && !dout_ready);
    chk("valid_at_end", 32'(dout_valid), 32'(ev));
    chk("frame_err", 32'(frame_err), 32'(fe));
    chk("overrun_err", 32'(overrun_err), 32'(ov));
    chk("parity_err", 32'(parity_err), 32'(pe));
    if (ld) begin
      chk("dout_load", 32'(dout), 32'(d));
      exp_q.push_back(d);
      if (!dout_ready) mdl_full = 1;
    end
    if (fe) e_fe++;
    if (ov) e_ov++;
    if (pe) e_pe++;
    rx = 1'b1;
    ticks(OS / 2 + 2);
  endtask

  initial begin
    logic [ND-1:0] d;
    repeat (4) @(negedge clock);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_pe", 32'(parity_err), 32'd0);
    chk("rst_ov", 32'(overrun_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    ticks(4);

    send_frame(8'h55, 0, 0, -1);
    chk("valid_one_cycle", 32'(dout_valid), 32'd0);
    sync("basic");

    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(6);
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    ticks(6);
    sync("glitch");

    send_frame(8'hFF, 0, 0, 3);
    sync("noise");

    send_frame(8'hA3, 1, 0, -1);
    chk("ferr_no_valid", 32'(dout_valid), 32'd0);
    sync("framing");

    dout_ready = 1'b0;
    send_frame(8'h12, 0, 0, -1);
    send_frame(8'h34, 0, 0, -1);
    chk("ovr_dout_kept", 32'(dout), 32'h12);
    chk("ovr_valid_kept", 32'(dout_valid), 32'd1);
    release_hold();
    chk("ovr_drained", 32'(dout_valid), 32'd0);
    sync("overrun");

    send_frame(8'h07, 0, 1, -1);
    send_frame(8'h07, 0, 0, -1);
    sync("parity");

    rx = 1'b0;
    ticks(2 * T1 + 2);
    rx = 1'b1;
    ticks(OS);
    e_fe += 2;
    chk("break_idle", 32'(rx_busy), 32'd0);
    sync("break");

    d = 8'h5A;
    rx = 1'b0;
    ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      ticks(OS);
    end
    rx = d[4];
    ticks(5);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_busy", 32'(rx_busy), 32'd0);
    chk("mid_rst_fe", 32'(frame_err), 32'd0);
    reset = 1'b0;
    rx = 1'b1;
    ticks(2 * OS);
    sync("mid_reset");
    send_frame(8'hC3, 0, 0, -1);
    sync("after_reset");

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0)
        dout_ready = 1'b0;
      else
        release_hold();
      d = ND'($urandom());
      send_frame(d,
        $urandom_range(0, 4) == 0,
        $urandom_range(0, 1) == 1,
        ($urandom_range(0, 1) == 1) ?
          int'($urandom_range(0, ND - 1)) : -1);
    end
    release_hold();
    sync("random");

    chk("pulse_rules", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_uart_gen.md
# rx_uart_gen

Parametrised UART receiver that replaces the fixed 8N1 receiver in the serial front end feeding the MIPS debug/loader path. It adds configurable data width, oversampling ratio and stop-bit count, majority-of-three bit sampling behind a two-flop synchroniser, optional parity, and framing, parity and overrun error reporting. Received words are delivered through a one-entry valid/ready holding register instead of a bare done pulse.

## Interface
- `N_DATA`, 8: data bits per frame, 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit, even, 8..32.
- `N_STOP`, 1: stop bits, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Used only when `RX_UART_GEN_PARITY_EN` is defined.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial line, idles high.
- `s_tick`  in  1  one-cycle oversampling strobe from the baud generator.
- `dout`  out  N_DATA  received word, LSB first on the line, so `dout[0]` is the first data bit.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout`.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun_err`  out  1  one-cycle pulse: a completed frame was dropped.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- **Input conditioning:** `rx` passes through a 2-flop synchroniser. Its reset value is 1, so no false start occurs after reset.
- **Majority sample:** each `s_tick` shifts the synchronised bit into a 3-bit history. The majority of these three values is the bit "sampled" at a decision tick.
- **IDLE:** when the synchronised `rx` is 0, clear the tick counter and go to START.
- **START:** the tick counter advances on each `s_tick`. At count `OVERSAMPLE/2-1`:
  - majority 0: clear both counters and go to DATA;
  - majority 1: treat the start as a glitch and return to IDLE.
- **DATA:**
  - The counter runs 0..`OVERSAMPLE-1`. At `OVERSAMPLE-1`, shift the sample into the MSB of the shift register (shift right) and clear the counter.
  - After the `N_DATA`th bit, go to PARITY if enabled, otherwise to STOP.
- **PARITY** (macro only): sample one bit in the same way. The expected value is the XOR of the data bits, inverted when `PARITY_ODD`. A mismatch sets an internal flag.
- **STOP:**
  - Sample `N_STOP` bits, one every `OVERSAMPLE` ticks. Any 0 sets an internal framing flag.
  - After the last stop decision, always return to IDLE, then complete the frame as below.
- **Frame completion:**
  - Framing error: pulse `frame_err`, discard the word, leave `dout`/`dout_valid` unchanged.
  - Otherwise, if the holding register is free or is consumed this same cycle (`dout_valid && dout_ready`): load `dout`, set `dout_valid`, and pulse `parity_err` if flagged. Parity-error words are still delivered.
  - Otherwise: pulse `overrun_err`, drop the new word, keep the held word.
- **Handshake:**
  - A transfer occurs when `dout_valid && dout_ready`, and `dout_valid` clears the next cycle unless a new word loads in that cycle.
  - `dout` is stable while `dout_valid` is high.
- **Break (`rx` held low):** each frame period produces `frame_err`, then IDLE restarts immediately. No words are delivered.
- **Widths:**
  - Tick counter is `$clog2(OVERSAMPLE)` bits.
  - Bit counter is `$clog2(N_DATA+1)` bits.
  - Counters never wrap mid-bit, because they are explicitly cleared at each decision.

## Timing
- **Reset:** all outputs 0, state IDLE, counters 0, synchroniser and history all 1s. Reset mid-frame aborts the frame and delivers nothing.
- **Stalls:** with `s_tick` low, all counters and state hold. Only the IDLE→START transition and the handshake act without `s_tick`.
- **Input latency:** 2 cycles from `rx` to the synchronised bit.
- **Output latency:** `dout_valid` and the error pulses are registered and assert the cycle after the `s_tick` of the last stop decision.
- **Error pulses:** all error outputs are exactly one cycle wide and mutually exclusive per frame, except that `parity_err` may accompany a successful load.

## Configuration
- `RX_UART_GEN_PARITY_EN` defined: the PARITY state exists, the frame is start + `N_DATA` + parity + `N_STOP`, and `PARITY_ODD` is honoured.
- Undefined: no PARITY state or parity logic, `parity_err` is tied 0, and the frame is start + `N_DATA` + `N_STOP`.

## Structure
- **Package `rx_uart_gen_pkg`:** one-hot state encodings (IDLE, START, DATA, PARITY, STOP, 5 bits) and a `majority3` function.
- **Sub-module `rx_uart_sampler`:** 2-flop synchroniser plus the `s_tick`-gated 3-bit history. Outputs are the synchronised bit and the majority bit.

## Test plan
- **Basic 8N1, 0x55** (`OVERSAMPLE`=16, `N_DATA`=8, `N_STOP`=1, ready held high) → `dout`=0x55, `dout_valid` high one cycle, no errors.
- **Start glitch,** `rx` low for 4 ticks → START returns to IDLE, no `dout_valid` and no error pulses.
- **Noise rejection:** single-tick low spike at the centre of data bit 3 of 0xFF → `dout`=0xFF. **Framing:** stop bit low on 0xA3 → `frame_err` pulse, `dout_valid` stays 0.
- **Overrun:** 0x12 then 0x34 with `dout_ready`=0 → `overrun_err` at the second completion. `dout` stays 0x12, and raising ready delivers 0x12 only.
- **Parity** (macro defined, `PARITY_ODD`=1): 0x07 with parity bit 1 → `dout`=0x07 valid plus `parity_err`. With parity bit 0 → no error.
- **Reset mid-frame:** reset asserted during data bit 4 → all outputs 0, no delivery. The next clean frame 0xC3 is received correctly.
